// File: rtl/out_stream_framer_pkg.sv
// out_stream_framer_pkg
//   Shared constants, FSM state type and header-word builder for the
//   output stream framer. Imported by the interface, the sequence-counter
//   bank and the framer top.
package out_stream_framer_pkg;

  // Number of upstream sources merged by the arbiter, and the ID width.
  localparam int IN_INTERFACES_NUM     = 4;
  localparam int IN_INTERFACE_ID_WIDTH = $clog2(IN_INTERFACES_NUM);

  // Widest header the builder can produce; callers truncate to DATA_WIDTH.
  localparam int HDR_MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    DROP    = 2'd2
  } state_t;

  // Header word = {source ID, per-source sequence number}. The sequence
  // field occupies the low seq_width bits, the ID sits directly above it.
  function automatic logic [HDR_MAX_WIDTH-1:0] build_header(
    input int unsigned                      seq_width,
    input logic [IN_INTERFACE_ID_WIDTH-1:0] id,
    input logic [HDR_MAX_WIDTH-1:0]         seq
  );
    return (HDR_MAX_WIDTH'(id) << seq_width) | seq;
  endfunction

endpackage

// File: rtl/out_stream_framer_if.sv
// out_stream_framer_if
//   Bundles the framer's upstream (merged arbiter output) and downstream
//   stream signals.
//   Handshake: a word moves on a side when valid && ready are both high at
//   a rising clk edge; a source holding valid keeps its payload stable until
//   that transfer; ready may be asserted independently of valid.
//   modport master : used by the framer (drives in_ready and out_*).
//   modport slave  : used by the surrounding logic (drives in_* and out_ready).
interface out_stream_framer_if
  import out_stream_framer_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) ();

  logic                             in_valid;
  logic                             in_ready;
  logic [DATA_WIDTH-1:0]            in_data;
  logic [IN_INTERFACE_ID_WIDTH-1:0] in_data_source_id;
  logic                             in_data_last;

  logic                             out_valid;
  logic                             out_ready;
  logic [DATA_WIDTH-1:0]            out_data;
  logic                             out_data_header;
  logic                             out_data_last;

  modport master (
    input  in_valid, in_data, in_data_source_id, in_data_last, out_ready,
    output in_ready, out_valid, out_data, out_data_header, out_data_last
  );

  modport slave (
    output in_valid, in_data, in_data_source_id, in_data_last, out_ready,
    input  in_ready, out_valid, out_data, out_data_header, out_data_last
  );

endinterface

// File: rtl/out_stream_framer_seq_bank.sv
// out_stream_framer_seq_bank
//   One SEQ_WIDTH-bit frame sequence counter per source ID. Counters wrap
//   naturally modulo 2^SEQ_WIDTH and are independent of each other.
//   Ports:
//     clk, nreset : clock, asynchronous active-low reset (all counters -> 0)
//     rd_id       : source whose counter is presented on rd_seq
//     rd_seq      : current counter value for rd_id (combinational read)
//     inc_en      : increment the counter selected by inc_id this cycle
//     inc_id      : source whose counter is incremented
module out_stream_framer_seq_bank
  import out_stream_framer_pkg::*;
#(
  parameter int SEQ_WIDTH = 6
) (
  input  logic                             clk,
  input  logic                             nreset,
  input  logic [IN_INTERFACE_ID_WIDTH-1:0] rd_id,
  output logic [SEQ_WIDTH-1:0]             rd_seq,
  input  logic                             inc_en,
  input  logic [IN_INTERFACE_ID_WIDTH-1:0] inc_id
);

  logic [SEQ_WIDTH-1:0] seq_q [IN_INTERFACES_NUM];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < IN_INTERFACES_NUM; i++) begin
        seq_q[i] <= '0;
      end
    end else if (inc_en) begin
      seq_q[inc_id] <= seq_q[inc_id] + SEQ_WIDTH'(1);
    end
  end

  assign rd_seq = seq_q[rd_id];

endmodule

// File: rtl/out_stream_framer.sv
// out_stream_framer
//   Frames the arbiter's merged output stream: emits one header word
//   {source ID, per-source sequence number} ahead of each frame, forwards
//   payload through a registered valid/ready stage, truncates frames longer
//   than MAX_FRAME_LEN payload words and flags protocol errors.
//   Ports:
//     clk, nreset      : clock, asynchronous active-low reset
//     bus (master)     : in_* upstream stream, out_* downstream stream
//     err_len_overflow : one-cycle pulse, aligned with the forced-last word
//     err_src_mismatch : one-cycle pulse, aligned with a payload word whose
//                        source ID differs from the frame's captured ID
//     dbg_state        : current FSM state
//   DATA_WIDTH must exceed IN_INTERFACE_ID_WIDTH; MAX_FRAME_LEN must be >= 1.
module out_stream_framer
  import out_stream_framer_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_FRAME_LEN = 16
) (
  input  logic                clk,
  input  logic                nreset,
  out_stream_framer_if.master bus,
  output logic                err_len_overflow,
  output logic                err_src_mismatch,
  output state_t              dbg_state
);

  localparam int ID_W      = IN_INTERFACE_ID_WIDTH;
  localparam int SEQ_WIDTH = DATA_WIDTH - ID_W;
  localparam int CNT_WIDTH = $clog2(MAX_FRAME_LEN + 1);
  // word_cnt value of the word that, once loaded, reaches the length limit.
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(MAX_FRAME_LEN - 1);

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  word_cnt_q;
  logic [ID_W-1:0]       src_q;

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_header_q;
  logic                  out_last_q;

  logic                  load_ok;
  logic                  in_ready;
  logic                  load_hdr;
  logic                  load_pay;
  logic                  end_norm;
  logic                  end_ovf;
  logic                  mismatch;
  logic                  drop_end;
  logic [SEQ_WIDTH-1:0]  rd_seq;
  logic [DATA_WIDTH-1:0] header_word;

  // The output register may take a new word when empty or being drained.
  assign load_ok = !out_valid_q || bus.out_ready;

  out_stream_framer_seq_bank #(
    .SEQ_WIDTH (SEQ_WIDTH)
  ) u_seq_bank (
    .clk    (clk),
    .nreset (nreset),
    .rd_id  (bus.in_data_source_id),
    .rd_seq (rd_seq),
    .inc_en (load_hdr),
    .inc_id (bus.in_data_source_id)
  );

  assign header_word = DATA_WIDTH'(build_header(SEQ_WIDTH, bus.in_data_source_id,
                                                HDR_MAX_WIDTH'(rd_seq)));

  // State register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output/control decode. The header is built from the waiting word's ID
  // without consuming it, so in_ready stays low in IDLE.
  always_comb begin
    in_ready = 1'b0;
    load_hdr = 1'b0;
    load_pay = 1'b0;
    end_norm = 1'b0;
    end_ovf  = 1'b0;
    mismatch = 1'b0;
    drop_end = 1'b0;
    case (state_q)
      IDLE: begin
        load_hdr = bus.in_valid && load_ok;
      end
      PAYLOAD: begin
        in_ready = load_ok;
        load_pay = bus.in_valid && load_ok;
        // A last word exactly at the limit is a normal end, not an overflow.
        end_norm = load_pay && bus.in_data_last;
        end_ovf  = load_pay && !bus.in_data_last && (word_cnt_q == LAST_CNT);
        mismatch = load_pay && (bus.in_data_source_id != src_q);
      end
      DROP: begin
        in_ready = 1'b1;
        drop_end = bus.in_valid && bus.in_data_last;
      end
      default: ;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_hdr) state_d = PAYLOAD;
      PAYLOAD: begin
        if (end_norm)     state_d = IDLE;
        else if (end_ovf) state_d = DROP;
      end
      DROP:    if (drop_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output register, frame bookkeeping and error pulses
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      out_valid_q      <= 1'b0;
      out_data_q       <= '0;
      out_header_q     <= 1'b0;
      out_last_q       <= 1'b0;
      word_cnt_q       <= '0;
      src_q            <= '0;
      err_len_overflow <= 1'b0;
      err_src_mismatch <= 1'b0;
    end else begin
      err_len_overflow <= end_ovf;
      err_src_mismatch <= mismatch;
      if (load_hdr) begin
        out_valid_q  <= 1'b1;
        out_data_q   <= header_word;
        out_header_q <= 1'b1;
        out_last_q   <= 1'b0;
        src_q        <= bus.in_data_source_id;
        word_cnt_q   <= '0;
      end else if (load_pay) begin
        out_valid_q  <= 1'b1;
        out_data_q   <= bus.in_data;
        out_header_q <= 1'b0;
        out_last_q   <= end_norm || end_ovf;
        word_cnt_q   <= word_cnt_q + CNT_WIDTH'(1);
      end else if (bus.out_ready) begin
        out_valid_q  <= 1'b0;
      end
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.out_valid       = out_valid_q;
  assign bus.out_data        = out_data_q;
  assign bus.out_data_header = out_header_q;
  assign bus.out_data_last   = out_last_q;
  assign dbg_state           = state_q;

endmodule

// File: tb/tb_out_stream_framer.sv
// tb_out_stream_framer
//   Directed bench for out_stream_framer (DATA_WIDTH=8, MAX_FRAME_LEN=16).
//   Inputs change on the falling clock edge; outputs are read on the falling
//   edge or 1 ns after it. Expected output words ({header, last, data}) are
//   queued in exp_q by the stimulus and consumed by an output monitor.
module tb_out_stream_framer;
  import out_stream_framer_pkg::*;

  localparam int DW  = 8;
  localparam int MAX = 16;

  logic   clk = 1'b0;
  logic   nreset;
  logic   err_len_overflow;
  logic   err_src_mismatch;
  state_t dbg_state;

  out_stream_framer_if #(.DATA_WIDTH(DW)) bus ();

  out_stream_framer #(
    .DATA_WIDTH    (DW),
    .MAX_FRAME_LEN (MAX)
  ) dut (
    .clk              (clk),
    .nreset           (nreset),
    .bus              (bus),
    .err_len_overflow (err_len_overflow),
    .err_src_mismatch (err_src_mismatch),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int n_ovf    = 0;
  int n_mis    = 0;
  logic [9:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: a transfer happens at the next rising edge when
  // valid && ready are seen here.
  always begin
    logic [9:0] got;
    logic [9:0] e;
    @(negedge clk);
    #1;
    if (nreset && bus.out_valid && bus.out_ready) begin
      got = {bus.out_data_header, bus.out_data_last, bus.out_data};
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $error("FAIL out_extra: observed %0h expected none", got);
      end else begin
        e = exp_q.pop_front();
        chk("out_word", 32'(got), 32'(e));
      end
    end
    if (err_len_overflow) begin
      n_ovf++;
      chk("ovf_on_last", 32'(bus.out_data_last), 32'd1);
    end
    if (err_src_mismatch) n_mis++;
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [1:0] src, input logic [7:0] d, input logic last,
                           output int waited);
    logic got;
    bus.in_valid          = 1'b1;
    bus.in_data           = d;
    bus.in_data_source_id = src;
    bus.in_data_last      = last;
    waited = 0;
    got    = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if (bus.in_ready) got = 1'b1;
      else begin
        waited++;
        @(negedge clk);
      end
    end
    chk("in_handshake", 32'(got), 32'd1);
    if (got) @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Sends n words first, first+step, ... with last on word n; queues the
  // expected header plus at most MAX payload words (forced last at MAX).
  task automatic send_frame(input logic [1:0] src, input logic [7:0] hdr, input int n,
                            input logic [7:0] first, input logic [7:0] step);
    int         waited;
    logic [7:0] d;
    exp_q.push_back({1'b1, 1'b0, hdr});
    d = first;
    for (int k = 0; k < n; k++) begin
      if (k < MAX) exp_q.push_back({1'b0, (k == n - 1) || (k == MAX - 1), d});
      send_word(src, d, k == n - 1, waited);
      chk(k == 0 ? "in_stall_hdr" : "in_stall", 32'(waited), k == 0 ? 32'd1 : 32'd0);
      d = d + step;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int         w;
    logic [7:0] rd;

    nreset                = 1'b0;
    bus.in_valid          = 1'b0;
    bus.in_data           = '0;
    bus.in_data_source_id = '0;
    bus.in_data_last      = 1'b0;
    bus.out_ready         = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_err_len", 32'(err_len_overflow), 32'd0);
    chk("rst_err_src", 32'(err_src_mismatch), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    nreset = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);

    // Basic frame src=2 and a second frame with the next sequence number.
    send_frame(2'd2, 8'h80, 3, 8'h11, 8'h11);
    send_frame(2'd2, 8'h81, 1, 8'h44, 8'h00);

    // Backpressure mid-frame, src=2 third frame.
    exp_q.push_back({1'b1, 1'b0, 8'h82});
    exp_q.push_back({1'b0, 1'b0, 8'hA1});
    exp_q.push_back({1'b0, 1'b0, 8'hA2});
    exp_q.push_back({1'b0, 1'b0, 8'hA3});
    exp_q.push_back({1'b0, 1'b1, 8'hA4});
    send_word(2'd2, 8'hA1, 1'b0, w);
    chk("bp_first_stall", 32'(w), 32'd1);
    bus.out_ready         = 1'b0;
    bus.in_valid          = 1'b1;
    bus.in_data           = 8'hA2;
    bus.in_data_source_id = 2'd2;
    bus.in_data_last      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out_data", 32'(bus.out_data), 32'hA1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    send_word(2'd2, 8'hA2, 1'b0, w);
    chk("bp_resume", 32'(w), 32'd0);
    send_word(2'd2, 8'hA3, 1'b0, w);
    send_word(2'd2, 8'hA4, 1'b1, w);

    // Overflow: 20-word frame from src=3, then an exact-length frame.
    send_frame(2'd3, 8'hC0, 20, 8'h01, 8'h01);
    chk("ovf_count", 32'(n_ovf), 32'd1);
    chk("ovf_state_idle", 32'(dbg_state), 32'(IDLE));
    send_frame(2'd3, 8'hC1, 16, 8'h21, 8'h01);
    chk("exact_no_ovf", 32'(n_ovf), 32'd1);
    chk("exact_state_idle", 32'(dbg_state), 32'(IDLE));

    // Sequence wrap on src=0; src=1 remains at zero.
    for (int i = 0; i < 65; i++) begin
      rd = 8'($urandom_range(0, 255));
      send_frame(2'd0, 8'(i % 64), 1, rd, 8'h00);
    end
    send_frame(2'd1, 8'h40, 1, 8'h5A, 8'h00);

    // Source mismatch inside a src=1 frame; the word is still forwarded.
    exp_q.push_back({1'b1, 1'b0, 8'h41});
    exp_q.push_back({1'b0, 1'b0, 8'h51});
    exp_q.push_back({1'b0, 1'b0, 8'h52});
    exp_q.push_back({1'b0, 1'b1, 8'h53});
    send_word(2'd1, 8'h51, 1'b0, w);
    chk("mis_none_yet", 32'(err_src_mismatch), 32'd0);
    send_word(2'd3, 8'h52, 1'b0, w);
    chk("mis_pulse", 32'(err_src_mismatch), 32'd1);
    chk("mis_word_fwd", 32'(bus.out_data), 32'h52);
    send_word(2'd1, 8'h53, 1'b1, w);
    chk("mis_pulse_end", 32'(err_src_mismatch), 32'd0);
    chk("mis_count", 32'(n_mis), 32'd1);

    // Reset in the middle of a src=1 frame.
    exp_q.push_back({1'b1, 1'b0, 8'h42});
    exp_q.push_back({1'b0, 1'b0, 8'h61});
    send_word(2'd1, 8'h61, 1'b0, w);
    #2;
    nreset = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'(IDLE));
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("midrst_queue", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    send_frame(2'd1, 8'h40, 1, 8'h71, 8'h00);
    send_frame(2'd2, 8'h80, 2, 8'h81, 8'h01);

    repeat (4) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_ovf_total", 32'(n_ovf), 32'd1);
    chk("final_mis_total", 32'(n_mis), 32'd1);
    chk("final_out_valid", 32'(bus.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/out_stream_framer.md
Name: out_stream_framer

Overview:
- Sits directly downstream of the arbiter top-level output interface; consumes its merged stream (data, source ID, last flag).
- Inserts one header word before each frame, with the source ID and a per-source frame sequence number.
- Forwards payload through a registered valid/ready stage, enforces a maximum frame length, and flags protocol errors.

Parameters:
- DATA_WIDTH, 8, bits per data word; must be greater than IN_INTERFACE_ID_WIDTH.
- MAX_FRAME_LEN, 16, maximum payload words per frame; must be at least 1.
- IN_INTERFACES_NUM (local), 4, number of possible source IDs.
- IN_INTERFACE_ID_WIDTH (local), $clog2(IN_INTERFACES_NUM) = 2.
- SEQ_WIDTH (local), DATA_WIDTH - IN_INTERFACE_ID_WIDTH = 6.
- CNT_WIDTH (local), $clog2(MAX_FRAME_LEN+1).

Ports:
- clk  input  1  clock.
- nreset  input  1  asynchronous reset, active low.
- in_valid  input  1  upstream valid.
- in_ready  output  1  upstream ready.
- in_data  input  DATA_WIDTH  upstream data.
- in_data_source_id  input  IN_INTERFACE_ID_WIDTH  upstream source ID.
- in_data_last  input  1  upstream last word of frame.
- out_valid  output  1  registered valid.
- out_ready  input  1  downstream ready.
- out_data  output  DATA_WIDTH  header or payload word.
- out_data_header  output  1  current out_data is a header word.
- out_data_last  output  1  last word of output frame.
- err_len_overflow  output  1  one-cycle pulse when a frame is truncated.
- err_src_mismatch  output  1  one-cycle pulse when a payload word's source ID differs from the frame's ID.

Behaviour:
- Reset (async assert, sync-released use):
  - All outputs 0, state IDLE, word_cnt 0, all seq[] counters 0, captured src 0.
  - Reset mid-frame discards the frame silently; the downstream sees out_valid drop to 0 immediately.
- Output register:
  - load_ok = !out_valid || out_ready.
  - out_valid clears when out_ready and nothing loads; out_* hold while out_valid && !out_ready.
- Transfer definitions: upstream transfer = in_valid && in_ready; downstream transfer = out_valid && out_ready.
- IDLE:
  - in_ready = 0.
  - If in_valid && load_ok: load header {in_data_source_id, seq[in_data_source_id]} with header=1, last=0; capture src; increment seq[src] mod 2^SEQ_WIDTH; word_cnt = 0; go to PAYLOAD.
  - Header is visible on out_* the cycle after in_valid is sampled. Header does not consume the input word.
- PAYLOAD:
  - in_ready = load_ok.
  - On upstream transfer: load in_data with header=0; word_cnt++.
  - If in_data_last: out_data_last = 1, go to IDLE.
  - Else if word_cnt+1 == MAX_FRAME_LEN: out_data_last = 1 (forced), pulse err_len_overflow, go to DROP.
  - If in_data_source_id != src: pulse err_src_mismatch; the word is still forwarded and src is not updated.
- DROP:
  - in_ready = 1, output register not loaded, words discarded.
  - On a transfer with in_data_last: go to IDLE.
  - A last word arriving exactly at word MAX_FRAME_LEN is a normal end, not an overflow.
- Throughput: one word per cycle in PAYLOAD with out_ready held high; one bubble-free header cycle per frame (the header costs one input-stall cycle).
- Simultaneous IDLE entry and new in_valid: the header for the next frame loads the cycle after the last payload is loaded (IDLE lasts at least 1 cycle).
- Sequence counters wrap 63 -> 0 per source, independently.
- Error pulses last exactly one cycle, registered, aligned with the cycle the offending word loads (or would load in PAYLOAD).

Decomposition:
- Package out_stream_framer_pkg holds:
  - IN_INTERFACES_NUM and IN_INTERFACE_ID_WIDTH constants;
  - the state typedef enum {IDLE, PAYLOAD, DROP};
  - a function to build the header word.
- Sub-module out_stream_framer_seq_bank: IN_INTERFACES_NUM counters of SEQ_WIDTH bits, with read by ID and increment by ID.

Test Plan:
- Single frame, src=2, 3 words 0x11,0x22,0x33 (last on 0x33), out_ready=1 -> out: header 0x80 (hdr=1), then 0x11, 0x22, 0x33 with last=1; a second src=2 frame gives header 0x81.
- Backpressure: hold out_ready=0 for 3 cycles mid-frame -> out_data stable, in_ready=0, no word lost or duplicated; order preserved.
- Overflow, MAX_FRAME_LEN=16: 20-word frame -> 16 payload words out, word 16 has last=1, err_len_overflow pulses once, words 17-20 consumed with in_ready=1 and not output.
- Exact length: 16-word frame with last on word 16 -> no err_len_overflow, normal IDLE return.
- Seq wrap: 64 single-word frames from src=0 -> headers 0x00..0x3F, the 65th header is 0x00; src=1 headers start at 0x40, unaffected.
- Source mismatch and reset: a src=1 frame with word 2 tagged src=3 -> err_src_mismatch pulse, word forwarded. Asserting nreset mid-frame -> out_valid=0 at once, seq counters 0.
